// File: rtl/collision_unit_if.sv
// Bus between the pipeline's EX stage and the collision coprocessor.
// Carries table writes, operation requests and the result/handshake signals.
interface collision_unit_if #(
    parameter int COORD_W   = 8,
    parameter int NUM_SLOTS = 8
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    logic                   wr_en;
    logic [SLOT_W-1:0]      wr_slot;
    logic [4*COORD_W-1:0]   wr_box;
    logic                   start;
    logic                   mode;
    logic [4*COORD_W-1:0]   box_a;
    logic [4*COORD_W-1:0]   box_b;
    logic [NUM_SLOTS-1:0]   slot_mask;
    logic                   busy;
    logic                   done;
    logic                   hit;
    logic [NUM_SLOTS-1:0]   hit_mask;
    logic [SLOT_W-1:0]      first_hit;

    modport master (
        output wr_en, wr_slot, wr_box, start, mode, box_a, box_b, slot_mask,
        input  busy, done, hit, hit_mask, first_hit
    );

    modport slave (
        input  wr_en, wr_slot, wr_box, start, mode, box_a, box_b, slot_mask,
        output busy, done, hit, hit_mask, first_hit
    );
endinterface

// File: rtl/collision_unit.sv
// Hitbox collision coprocessor: a box table plus a pair compare (1 cycle)
// and a scan of the query box against every enabled slot (one slot per cycle).
module collision_unit #(
    parameter int COORD_W   = 8,
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    collision_unit_if.slave       bus
);
    localparam int BOX_W = 4 * COORD_W;

    typedef enum logic [1:0] {S_IDLE, S_PAIR, S_SCAN, S_FIN} state_t;

    state_t                 state_q, state_d;
    logic [BOX_W-1:0]       table_q [NUM_SLOTS];
    logic [BOX_W-1:0]       a_q, b_q;
    logic [NUM_SLOTS-1:0]   mask_q;
    logic [SLOT_W-1:0]      cnt_q, cnt_d;
    logic                   hit_q, hit_d;
    logic [NUM_SLOTS-1:0]   hit_mask_q, hit_mask_d;
    logic [SLOT_W-1:0]      first_hit_q, first_hit_d;
    logic                   busy, done, accept, pair_r, scan_r;

    // Sums are widened by one bit so boxes near the top of the coordinate
    // range never wrap; zero-sized boxes are rejected explicitly because the
    // interval test alone would let them sit strictly inside another box.
    function automatic logic overlap(input logic [BOX_W-1:0] a, input logic [BOX_W-1:0] b);
        logic [COORD_W:0] ax, ay, aw, ah, bx, by, bw, bh;
        ax = {1'b0, a[4*COORD_W-1 -: COORD_W]};
        ay = {1'b0, a[3*COORD_W-1 -: COORD_W]};
        aw = {1'b0, a[2*COORD_W-1 -: COORD_W]};
        ah = {1'b0, a[COORD_W-1   -: COORD_W]};
        bx = {1'b0, b[4*COORD_W-1 -: COORD_W]};
        by = {1'b0, b[3*COORD_W-1 -: COORD_W]};
        bw = {1'b0, b[2*COORD_W-1 -: COORD_W]};
        bh = {1'b0, b[COORD_W-1   -: COORD_W]};
        return (aw != '0) && (ah != '0) && (bw != '0) && (bh != '0) &&
               (ax < bx + bw) && (bx < ax + aw) &&
               (ay < by + bh) && (by < ay + ah);
    endfunction

    assign accept = bus.start && ((state_q == S_IDLE) || (state_q == S_FIN));
    assign pair_r = overlap(a_q, b_q);
    assign scan_r = mask_q[cnt_q] && overlap(a_q, table_q[cnt_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (accept) state_d = bus.mode ? S_SCAN : S_PAIR;
                else        state_d = S_IDLE;
            end
            S_PAIR: state_d = S_FIN;
            S_SCAN: if (cnt_q == SLOT_W'(NUM_SLOTS - 1)) state_d = S_FIN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_PAIR, S_SCAN: busy = 1'b1;
            S_FIN:          done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        hit_d       = hit_q;
        hit_mask_d  = hit_mask_q;
        first_hit_d = first_hit_q;
        if (accept) begin
            cnt_d       = '0;
            hit_d       = 1'b0;
            hit_mask_d  = '0;
            first_hit_d = '0;
        end else if (state_q == S_PAIR) begin
            hit_d       = pair_r;
            hit_mask_d  = {{(NUM_SLOTS-1){1'b0}}, pair_r};
            first_hit_d = '0;
        end else if (state_q == S_SCAN) begin
            hit_mask_d[cnt_q] = scan_r;
            hit_d             = hit_q | scan_r;
            if (scan_r && !hit_q) first_hit_d = cnt_q;
            cnt_d             = cnt_q + SLOT_W'(1);
        end
    end

    // Table reads during a scan are combinational off table_q, so a write in
    // the same cycle as a slot's evaluation is only visible to later scans.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) table_q[i] <= '0;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            hit_mask_q  <= '0;
            first_hit_q <= '0;
        end else begin
            if (bus.wr_en && (32'(bus.wr_slot) < NUM_SLOTS)) table_q[bus.wr_slot] <= bus.wr_box;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            hit_mask_q  <= hit_mask_d;
            first_hit_q <= first_hit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q    <= bus.box_a;
            b_q    <= bus.box_b;
            mask_q <= bus.slot_mask;
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.hit       = hit_q;
    assign bus.hit_mask  = hit_mask_q;
    assign bus.first_hit = first_hit_q;
endmodule
